// File: rtl/ascon_permutation_engine.sv
// Ascon permutation core: p^a / p^b with start/done handshake, UNROLL rounds per clock, and
// pre-xor (xor_up) / post-xor (xor_down) stages. Define ASCON_PERM_ABORT_EN to add abort_i.
module ascon_permutation_engine #(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned RATE_WORDS = 1
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      load_i,
  input  logic                      rounds12_i,
  input  logic [319:0]              state_i,
  input  logic [127:0]              xor_key_i,
  input  logic [64*RATE_WORDS-1:0]  xor_data_i,
  input  logic [1:0]                xor_up_mode_i,
  input  logic [1:0]                xor_down_mode_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic                      abort_i,
`endif
  output logic [319:0]              state_o,
  output logic                      busy_o,
  output logic                      done_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("ascon_permutation_engine: UNROLL must be 1, 2, 3 or 6");
  end
  if (!(RATE_WORDS == 1 || RATE_WORDS == 2)) begin : g_bad_rate
    $error("ascon_permutation_engine: RATE_WORDS must be 1 or 2");
  end

  typedef enum logic {StIdle, StRun} fsm_e;

  fsm_e         fsm_q;
  logic [3:0]   round_q;
  logic [127:0] key_q;
  logic [1:0]   down_q;

  logic [319:0] up_state;
  logic [319:0] run_state;
  logic [4:0]   round_sum;
  logic         last_group;
  logic         abort;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One round on {x0,x1,x2,x3,x4}, x0 in the top 64 bits.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2[7:0] = x2[7:0] ^ {4'hF - r, r};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Data word w lands in xw, where word w is xor_data_i[64*w +: 64].
  function automatic logic [319:0] xor_up(input logic [319:0] s, input logic [1:0] mode,
                                          input logic [127:0] key,
                                          input logic [64*RATE_WORDS-1:0] data);
    logic [319:0] r;
    r = s;
    if (mode[0]) begin
      for (int w = 0; w < int'(RATE_WORDS); w++) begin
        r[319 - 64*w -: 64] = r[319 - 64*w -: 64] ^ data[64*w +: 64];
      end
    end
    if (mode[1]) begin
      r[319 - 64*RATE_WORDS -: 64] = r[319 - 64*RATE_WORDS -: 64] ^ key[127:64];
      r[255 - 64*RATE_WORDS -: 64] = r[255 - 64*RATE_WORDS -: 64] ^ key[63:0];
    end
    return r;
  endfunction

  function automatic logic [319:0] xor_down(input logic [319:0] s, input logic [1:0] mode,
                                            input logic [127:0] key);
    logic [319:0] r;
    r = s;
    if (mode[0]) begin
      r[127:64] = r[127:64] ^ key[127:64];
      r[63:0]   = r[63:0] ^ key[63:0];
    end
    if (mode[1]) begin
      r[0] = ~r[0];
    end
    return r;
  endfunction

`ifdef ASCON_PERM_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign up_state   = xor_up(load_i ? state_i : state_o, xor_up_mode_i, xor_key_i, xor_data_i);
  assign round_sum  = 5'(round_q) + 5'(UNROLL);
  assign last_group = (round_sum == 5'd12);

  always_comb begin
    run_state = state_o;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      run_state = ascon_round(run_state, round_q + 4'(u));
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= StIdle;
      round_q <= '0;
      key_q   <= '0;
      down_q  <= '0;
      state_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start_i) begin
            state_o <= up_state;
            round_q <= rounds12_i ? 4'd0 : 4'd6;
            key_q   <= xor_key_i;
            down_q  <= xor_down_mode_i;
            busy_o  <= 1'b1;
            fsm_q   <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            busy_o <= 1'b0;
            fsm_q  <= StIdle;
          end else if (last_group) begin
            state_o <= xor_down(run_state, down_q, key_q);
            round_q <= round_sum[3:0];
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            fsm_q   <= StIdle;
          end else begin
            state_o <= run_state;
            round_q <= round_sum[3:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: two instances (UNROLL=1/RATE_WORDS=1 and
// UNROLL=3/RATE_WORDS=2) checked against a column-wise S-box-table model of the permutation.
module tb_ascon_permutation_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic         load;
  logic         r12;
  logic [319:0] st;
  logic [127:0] key;
  logic [127:0] data;
  logic [1:0]   up;
  logic [1:0]   dn;
`ifdef ASCON_PERM_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic [319:0] so1, so3;
  logic         busy1, busy3, done1, done3;

  int errors = 0;
  int checks = 0;
  logic [319:0] exp1 = '0;
  logic [319:0] exp3 = '0;

  ascon_permutation_engine #(.UNROLL(1), .RATE_WORDS(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .load_i(load), .rounds12_i(r12),
    .state_i(st), .xor_key_i(key), .xor_data_i(data[63:0]), .xor_up_mode_i(up),
    .xor_down_mode_i(dn),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .state_o(so1), .busy_o(busy1), .done_o(done1)
  );

  ascon_permutation_engine #(.UNROLL(3), .RATE_WORDS(2)) dut3 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .load_i(load), .rounds12_i(r12),
    .state_i(st), .xor_key_i(key), .xor_data_i(data), .xor_up_mode_i(up),
    .xor_down_mode_i(dn),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .state_o(so3), .busy_o(busy3), .done_o(done3)
  );

  // Reference model: 5-bit S-box applied per bit column (x0 = MSB of the column index).
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    logic [7:0]  c;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    c = 8'((15 - r) * 16 + r);
    x[2] = x[2] ^ {56'd0, c};
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SBOX[col];
      for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
    end
    for (int i = 0; i < 5; i++) begin
      s[319 - 64*i -: 64] = y[i] ^ rotr(y[i], ROT_A[i]) ^ rotr(y[i], ROT_B[i]);
    end
    return s;
  endfunction

  function automatic logic [319:0] m_rounds(input logic [319:0] s, input int first,
                                            input int count);
    for (int r = first; r < first + count; r++) s = m_round(s, r);
    return s;
  endfunction

  function automatic logic [319:0] m_up(input logic [319:0] s, input logic [1:0] m,
                                        input logic [127:0] k, input logic [127:0] d,
                                        input int rw);
    logic [63:0] x [5];
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    if (m[0]) for (int w = 0; w < rw; w++) x[w] = x[w] ^ d[64*w +: 64];
    if (m[1]) begin
      x[rw]     = x[rw] ^ k[127:64];
      x[rw + 1] = x[rw + 1] ^ k[63:0];
    end
    for (int i = 0; i < 5; i++) s[319 - 64*i -: 64] = x[i];
    return s;
  endfunction

  function automatic logic [319:0] m_down(input logic [319:0] s, input logic [1:0] m,
                                          input logic [127:0] k);
    if (m[0]) begin
      s[127:64] = s[127:64] ^ k[127:64];
      s[63:0]   = s[63:0] ^ k[63:0];
    end
    if (m[1]) s[63:0] = s[63:0] ^ 64'h1;
    return s;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string nm, input logic [319:0] act, input logic [319:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  typedef struct {
    string        name;
    bit           ld;
    bit           r12;
    logic [1:0]   up;
    logic [1:0]   dn;
    logic [319:0] st;
    logic [127:0] key;
    logic [127:0] data;
    int           n1;
    int           n3;
    bit           poke;
  } vec_t;

  function automatic vec_t mk(input string name, input bit ld, input bit rr, input logic [1:0] u,
                              input logic [1:0] d, input logic [319:0] s, input logic [127:0] k,
                              input logic [127:0] dat, input int n1, input int n3, input bit pk);
    vec_t v;
    v.name = name; v.ld = ld; v.r12 = rr; v.up = u; v.dn = d; v.st = s; v.key = k;
    v.data = dat; v.n1 = n1; v.n3 = n3; v.poke = pk;
    return v;
  endfunction

  // One run on both instances; poke re-asserts start with scrambled inputs while busy.
  task automatic run_vec(input vec_t v);
    logic [319:0] e1, e3, s1, s3;
    int nr, d1, d3;
    bit ok;
    nr = v.r12 ? 12 : 6;
    e1 = m_up(v.ld ? v.st : exp1, v.up, v.key, v.data, 1);
    e3 = m_up(v.ld ? v.st : exp3, v.up, v.key, v.data, 2);
    start = 1'b1; load = v.ld; r12 = v.r12; up = v.up; dn = v.dn;
    st = v.st; key = v.key; data = v.data;
    tick();
    start = 1'b0;
    check_vec({v.name, "/up1"}, so1, e1);
    check_vec({v.name, "/up3"}, so3, e3);
    check_int({v.name, "/flags0"}, int'({busy1, busy3, done1, done3}), 'b1100);
    e1 = m_down(m_rounds(e1, 12 - nr, nr), v.dn, v.key);
    e3 = m_down(m_rounds(e3, 12 - nr, nr), v.dn, v.key);
    d1 = -1; d3 = -1; ok = 1'b1; s1 = '0; s3 = '0;
    for (int c = 1; c <= 14; c++) begin
      if (v.poke && c == 2) begin
        start = 1'b1; load = 1'b1; r12 = ~v.r12; st = rand320();
        key = ~v.key; data = ~v.data; up = ~v.up; dn = ~v.dn;
      end
      tick();
      start = 1'b0;
      if (busy1 !== (c < v.n1) || busy3 !== (c < v.n3)) ok = 1'b0;
      if (done1) begin
        if (d1 < 0) begin d1 = c; s1 = so1; end else ok = 1'b0;
      end
      if (done3) begin
        if (d3 < 0) begin d3 = c; s3 = so3; end else ok = 1'b0;
      end
      if (d1 > 0 && so1 !== s1) ok = 1'b0;
      if (d3 > 0 && so3 !== s3) ok = 1'b0;
    end
    check_int({v.name, "/lat1"}, d1, v.n1);
    check_int({v.name, "/lat3"}, d3, v.n3);
    check_int({v.name, "/busy_done"}, int'(ok), 1);
    check_vec({v.name, "/res1"}, s1, e1);
    check_vec({v.name, "/res3"}, s3, e3);
    exp1 = e1;
    exp3 = e3;
  endtask

  localparam logic [127:0] KN = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    vec_t vecs [13];
    logic [31:0] m1, m3, x1, x3;
    logic [319:0] e1, e3;
    bit rr;
    bit ok;

    rst = 1'b1; start = 1'b0; load = 1'b0; r12 = 1'b0; st = '0; key = '0; data = '0;
    up = 2'b00; dn = 2'b00;

    vecs[0] = mk("init128", 1, 1, 2'b00, 2'b01, {64'h80400c0600000000, KN, KN}, KN, '0, 12, 4, 0);
    vecs[1] = mk("pb_zero", 1, 0, 2'b00, 2'b00, '0, '0, '0, 6, 2, 0);
    vecs[2] = mk("rate_ones", 0, 1, 2'b01, 2'b00, '0, KN, {128{1'b1}}, 12, 4, 0);
    vecs[3] = mk("key_cap", 1, 0, 2'b10, 2'b11, rand320(), {$urandom(), $urandom(),
                 $urandom(), $urandom()}, '0, 6, 2, 1);
    vecs[4] = mk("both", 0, 1, 2'b11, 2'b11, '0, KN, ~KN, 12, 4, 0);
    for (int i = 5; i < 13; i++) begin
      rr = 1'($urandom_range(0, 1));
      vecs[i] = mk($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), rr,
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rand320(),
                   {$urandom(), $urandom(), $urandom(), $urandom()},
                   {$urandom(), $urandom(), $urandom(), $urandom()},
                   rr ? 12 : 6, rr ? 4 : 2, 1'($urandom_range(0, 1)));
    end

    tick();
    tick();
    check_vec("reset_state1", so1, '0);
    check_vec("reset_state3", so3, '0);
    check_int("reset_flags", int'({busy1, busy3, done1, done3}), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // start held for 20 cycles: runs are accepted back-to-back, one per done cycle gap.
    load = 1'b1; r12 = 1'b1; up = 2'b11; dn = 2'b11; st = rand320();
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    data = {$urandom(), $urandom(), $urandom(), $urandom()};
    m1 = '0; m3 = '0; x1 = '0; x3 = '0;
    for (int t = 0; t < 20; t += 13) x1[t + 12] = 1'b1;
    for (int t = 0; t < 20; t += 5) x3[t + 4] = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c == 20) start = 1'b0;
      tick();
      if (done1) m1[c] = 1'b1;
      if (done3) m3[c] = 1'b1;
    end
    check_int("held_start_done1", int'(m1), int'(x1));
    check_int("held_start_done3", int'(m3), int'(x3));
    exp1 = m_down(m_rounds(m_up(st, up, key, data, 1), 0, 12), dn, key);
    exp3 = m_down(m_rounds(m_up(st, up, key, data, 2), 0, 12), dn, key);
    check_vec("held_start_res1", so1, exp1);
    check_vec("held_start_res3", so3, exp3);

    // Asynchronous reset in the middle of a p^a run.
    start = 1'b1; load = 1'b1; r12 = 1'b1; up = 2'b01; dn = 2'b01; st = rand320();
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    check_int("pre_reset_busy1", int'(busy1), 1);
    rst = 1'b1;
    #1;
    check_vec("async_reset1", so1, '0);
    check_vec("async_reset3", so3, '0);
    check_int("async_reset_flags", int'({busy1, busy3, done1, done3}), 0);
    #2;
    rst = 1'b0;
    exp1 = '0;
    exp3 = '0;
    run_vec(mk("after_reset", 0, 1, 2'b00, 2'b10, '0, KN, KN, 12, 4, 0));

`ifdef ASCON_PERM_ABORT_EN
    // start and abort together in IDLE start normally; abort later ends the run early.
    start = 1'b1; abort = 1'b1; load = 1'b1; r12 = 1'b1; up = 2'b01; dn = 2'b11;
    st = rand320(); data = {$urandom(), $urandom(), $urandom(), $urandom()};
    e1 = m_rounds(m_up(st, up, key, data, 1), 0, 2);
    e3 = m_rounds(m_up(st, up, key, data, 2), 0, 6);
    tick();
    start = 1'b0; abort = 1'b0;
    check_int("abort_start_busy", int'({busy1, busy3}), 'b11);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_int("abort_flags", int'({busy1, busy3, done1, done3}), 0);
    check_vec("abort_partial1", so1, e1);
    check_vec("abort_partial3", so3, e3);
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      abort = (c == 1);
      tick();
      if (done1 || done3 || busy1 || busy3 || so1 !== e1 || so3 !== e3) ok = 1'b0;
    end
    abort = 1'b0;
    check_int("abort_quiet", int'(ok), 1);
    exp1 = e1;
    exp3 = e3;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
